// File: rtl/lfsr_sng_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_sng_pkg
// Shared constants and helpers for the LFSR stochastic number generator bank.
//   MIN_WIDTH / MAX_WIDTH : legal LFSR widths
//   tap_mask(width)       : maximal-length Fibonacci feedback mask for a
//                           left-shifting LFSR (bit i set = s[i] feeds the XOR)
//   rotl(value, amt, w)   : rotate the low w bits of value left by amt
// ----------------------------------------------------------------------------
package lfsr_sng_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 16;

    typedef logic [MAX_WIDTH-1:0] lfsr_word_t;

    function automatic lfsr_word_t tap_mask(input int width);
        lfsr_word_t m;
        case (width)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h008E;   // 1+x^2+x^3+x^4+x^8 -> s[7]^s[3]^s[2]^s[1]
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic lfsr_word_t rotl(input lfsr_word_t value, input int amount,
                                        input int width);
        logic [2*MAX_WIDTH-1:0] wide;
        lfsr_word_t             mask;
        int                     a;
        a    = amount % width;
        mask = MAX_WIDTH'((32'd1 << width) - 32'd1);
        wide = {{MAX_WIDTH{1'b0}}, value & mask} << a;
        // bits pushed past the top of the w-bit field wrap back to the bottom
        return (wide[MAX_WIDTH-1:0] | MAX_WIDTH'(wide >> width)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_sng_bank_if.sv
// ----------------------------------------------------------------------------
// lfsr_sng_bank_if
// Control/data bundle of the LFSR SNG bank.
//   SEED  : reseed value          LOAD : reseed strobe     EN : step enable
//   PROB  : per-channel probability words, channel k at [k*WIDTH +: WIDTH]
//   RND   : current LFSR state    SN   : stochastic bits
//   VALID : SN belongs to the current seed sequence
//   WRAP  : one-cycle pulse at end of a full LFSR period
//   CNT   : per-channel ones count per period (only with LFSR_SNG_CNT_EN)
// Modports: master drives the controls, slave is the generator bank.
// ----------------------------------------------------------------------------
interface lfsr_sng_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [WIDTH-1:0]          SEED;
    logic                      LOAD;
    logic                      EN;
    logic [CHANNELS*WIDTH-1:0] PROB;
    logic [WIDTH-1:0]          RND;
    logic [CHANNELS-1:0]       SN;
    logic                      VALID;
    logic                      WRAP;
`ifdef LFSR_SNG_CNT_EN
    logic [CHANNELS*WIDTH-1:0] CNT;
`endif

    modport master (
        output SEED, LOAD, EN, PROB,
`ifdef LFSR_SNG_CNT_EN
        input  CNT,
`endif
        input  RND, SN, VALID, WRAP
    );

    modport slave (
        input  SEED, LOAD, EN, PROB,
`ifdef LFSR_SNG_CNT_EN
        output CNT,
`endif
        output RND, SN, VALID, WRAP
    );
endinterface

// File: rtl/lfsr_sng_chan.sv
// ----------------------------------------------------------------------------
// lfsr_sng_chan
// One stochastic number generator channel.
//   TRIG      : clock
//   r_k       : this channel's rotated view of the LFSR state
//   prob_k    : probability word
//   step      : an EN step happens this cycle
//   clear     : reset or reseed this cycle
//   sn        : registered stochastic bit (r_k <= prob_k of the last step)
//   wrap_step : (LFSR_SNG_CNT_EN) this step closes a full period
//   cnt       : (LFSR_SNG_CNT_EN) ones count of the last completed period
// Optional feature macro: LFSR_SNG_CNT_EN.
// ----------------------------------------------------------------------------
module lfsr_sng_chan #(
    parameter int WIDTH = 8
) (
    input  logic             TRIG,
    input  logic [WIDTH-1:0] r_k,
    input  logic [WIDTH-1:0] prob_k,
    input  logic             step,
    input  logic             clear,
    output logic             sn
`ifdef LFSR_SNG_CNT_EN
    ,
    input  logic             wrap_step,
    output logic [WIDTH-1:0] cnt
`endif
);

    logic hit;
    assign hit = (r_k <= prob_k);

    always_ff @(posedge TRIG) begin
        if (clear) begin
            sn <= 1'b0;
        end else if (step) begin
            sn <= hit;
        end
    end

`ifdef LFSR_SNG_CNT_EN
    logic [WIDTH-1:0] acc;

    // acc counts the running period; the closing step's own bit belongs to
    // the period it closes, so the latched total is acc + hit.
    always_ff @(posedge TRIG) begin
        if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            if (wrap_step) begin
                cnt <= acc + WIDTH'(hit);
                acc <= '0;
            end else begin
                acc <= acc + WIDTH'(hit);
            end
        end
    end
`endif

endmodule

// File: rtl/lfsr_sng_bank.sv
// ----------------------------------------------------------------------------
// lfsr_sng_bank
// Shared Fibonacci LFSR driving CHANNELS stochastic number generators.
// Ports:
//   TRIG  : clock, all state on posedge
//   RESET : synchronous active-high reset
//   bus   : lfsr_sng_bank_if.slave (SEED/LOAD/EN/PROB in, RND/SN/VALID/WRAP out,
//           CNT out with LFSR_SNG_CNT_EN)
// Parameters: WIDTH (4..16), CHANNELS (1..16), ROT_STEP (per-channel rotation).
// Optional feature macro: LFSR_SNG_CNT_EN adds per-channel period ones counters.
// ----------------------------------------------------------------------------
module lfsr_sng_bank
    import lfsr_sng_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ROT_STEP = 3
) (
    input  logic          TRIG,
    input  logic          RESET,
    lfsr_sng_bank_if.slave bus
);

    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(tap_mask(WIDTH));
    // last pc value of a period: 2^WIDTH - 2
    localparam logic [WIDTH-1:0] PC_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0]    s;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    seed_clean;
    logic                fb;
    logic                clear;
    logic                step;
    logic                valid;
    logic                wrap;
    logic [CHANNELS-1:0] sn_vec;

    assign seed_clean = (bus.SEED == '0) ? WIDTH'(1) : bus.SEED;
    assign fb         = ^(s & TAPS);
    assign clear      = RESET | bus.LOAD;
    assign step       = bus.EN & ~clear;

    always_ff @(posedge TRIG) begin
        if (clear) begin
            s     <= seed_clean;
            pc    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (bus.EN) begin
            // all-zero state would stick forever; recover to 1
            s     <= (s == '0) ? WIDTH'(1) : {s[WIDTH-2:0], fb};
            pc    <= (pc == PC_LAST) ? '0 : pc + WIDTH'(1);
            valid <= 1'b1;
            wrap  <= (pc == PC_LAST);
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef LFSR_SNG_CNT_EN
    logic [CHANNELS*WIDTH-1:0] cnt_vec;
    assign bus.CNT = cnt_vec;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam int ROT = (k * ROT_STEP) % WIDTH;
        logic [WIDTH-1:0] r_k;

        assign r_k = WIDTH'(rotl(MAX_WIDTH'(s), ROT, WIDTH));

        lfsr_sng_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .TRIG      (TRIG),
            .r_k       (r_k),
            .prob_k    (bus.PROB[k*WIDTH +: WIDTH]),
            .step      (step),
            .clear     (clear),
            .sn        (sn_vec[k])
`ifdef LFSR_SNG_CNT_EN
            ,
            .wrap_step (step & (pc == PC_LAST)),
            .cnt       (cnt_vec[k*WIDTH +: WIDTH])
`endif
        );
    end

    assign bus.RND   = s;
    assign bus.SN    = sn_vec;
    assign bus.VALID = valid;
    assign bus.WRAP  = wrap;

endmodule

// File: tb/tb_lfsr_sng_bank.sv
// ----------------------------------------------------------------------------
// tb_lfsr_sng_bank
// Self-checking bench for lfsr_sng_bank (WIDTH=8, CHANNELS=4, ROT_STEP=3).
// Directed scenarios plus randomized EN/LOAD/RESET/PROB traffic, all checked
// against a behavioural model of the generator bank.
// Optional feature macro: LFSR_SNG_CNT_EN (enables CNT checks).
// ----------------------------------------------------------------------------
module tb_lfsr_sng_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int RS = 3;

    logic TRIG;
    logic RESET;

    lfsr_sng_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    lfsr_sng_bank #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .ROT_STEP (RS)
    ) dut (
        .TRIG  (TRIG),
        .RESET (RESET),
        .bus   (bus)
    );

    initial TRIG = 1'b0;
    always #5 TRIG = ~TRIG;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int lfsr_next(input int v);
        int f;
        if (v == 0) return 1;
        f = ((v >> 7) ^ (v >> 3) ^ (v >> 2) ^ (v >> 1)) & 1;
        return ((v << 1) & 255) | f;
    endfunction

    function automatic int rot8(input int v, input int a);
        return ((v << a) | (v >> (8 - a))) & 255;
    endfunction

    function automatic int hit(input int v, input int k, input logic [31:0] prob);
        int p;
        p = int'((prob >> (8 * k)) & 32'hFF);
        return (rot8(v, (k * RS) % W) <= p) ? 1 : 0;
    endfunction

    int         m_s;
    int         m_pc;
    logic [3:0] m_sn;
    logic       m_valid;
    logic       m_wrap;
    int         m_acc [CH];
    int         m_cnt [CH];

    always @(posedge TRIG) begin
        if (RESET || bus.LOAD) begin
            m_s     <= (bus.SEED == 0) ? 1 : int'(bus.SEED);
            m_pc    <= 0;
            m_sn    <= '0;
            m_valid <= 1'b0;
            m_wrap  <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                m_acc[k] <= 0;
                m_cnt[k] <= 0;
            end
        end else if (bus.EN) begin
            for (int k = 0; k < CH; k++) begin
                m_sn[k] <= (hit(m_s, k, bus.PROB) == 1);
                if (m_pc == 254) begin
                    m_cnt[k] <= m_acc[k] + hit(m_s, k, bus.PROB);
                    m_acc[k] <= 0;
                end else begin
                    m_acc[k] <= m_acc[k] + hit(m_s, k, bus.PROB);
                end
            end
            m_s     <= lfsr_next(m_s);
            m_pc    <= (m_pc + 1) % 255;
            m_wrap  <= (m_pc == 254);
            m_valid <= 1'b1;
        end else begin
            m_wrap  <= 1'b0;
        end
    end

    always @(negedge TRIG) begin
        if (cmp_on) begin
            chk("rnd",   32'(bus.RND),   32'(m_s));
            chk("sn",    32'(bus.SN),    32'(m_sn));
            chk("valid", 32'(bus.VALID), 32'(m_valid));
            chk("wrap",  32'(bus.WRAP),  32'(m_wrap));
`ifdef LFSR_SNG_CNT_EN
            for (int k = 0; k < CH; k++)
                chk("cnt", 32'(bus.CNT[8*k +: 8]), 32'(m_cnt[k]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge TRIG);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen [256];
        int          distinct, wraps, wrap_at, steps, r;
        int          ones [CH];
        logic [7:0]  h_rnd;
        logic [3:0]  h_sn;
        logic        h_valid;
        bit          found;

        RESET = 1'b1; bus.LOAD = 1'b0; bus.EN = 1'b0; bus.SEED = 8'h01; bus.PROB = '0;
        repeat (2) tick();
        chk("reset_rnd",   32'(bus.RND),   32'h01);
        chk("reset_sn",    32'(bus.SN),    32'h0);
        chk("reset_valid", 32'(bus.VALID), 32'h0);
        chk("reset_wrap",  32'(bus.WRAP),  32'h0);
        cmp_on = 1'b1;

        // full period from seed 1, channel probabilities 0x80/0x00/0xFF/0x01
        RESET = 1'b0; bus.PROB = 32'h01FF0080; bus.EN = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int k = 0; k < CH; k++) ones[k] = 0;
        distinct = 0; wraps = 0; wrap_at = -1;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (i == 0) chk("first_step_rnd", 32'(bus.RND), 32'h02);
            if (!seen[bus.RND]) begin
                seen[bus.RND] = 1'b1;
                if (bus.RND != 0) distinct++;
            end
            for (int k = 0; k < CH; k++) ones[k] += int'(bus.SN[k]);
            if (bus.WRAP) begin
                wraps++;
                wrap_at = i;
            end
        end
        chk("distinct_states", 32'(distinct), 32'd255);
        chk("wrap_count",      32'(wraps),    32'd1);
        chk("wrap_step",       32'(wrap_at),  32'd254);
        chk("period_rnd",      32'(bus.RND),  32'h01);
        chk("ones_ch0", 32'(ones[0]), 32'd128);
        chk("ones_ch1", 32'(ones[1]), 32'd0);
        chk("ones_ch2", 32'(ones[2]), 32'd255);
        chk("ones_ch3", 32'(ones[3]), 32'd1);
        bus.EN = 1'b0;
        tick();
        chk("wrap_drop", 32'(bus.WRAP), 32'h0);

        // zero seed sanitised to 1
        RESET = 1'b1; bus.SEED = 8'h00;
        tick();
        RESET = 1'b0;
        chk("zseed_rnd",   32'(bus.RND),   32'h01);
        chk("zseed_valid", 32'(bus.VALID), 32'h0);
        chk("zseed_sn",    32'(bus.SN),    32'h0);
        bus.EN = 1'b1;
        tick();
        chk("zseed_valid1", 32'(bus.VALID), 32'h1);
        chk("zseed_rnd1",   32'(bus.RND),   32'h02);

        // EN pause mid-period
        repeat (99) tick();
        h_rnd = bus.RND; h_sn = bus.SN; h_valid = bus.VALID;
        bus.EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rnd",   32'(bus.RND),   32'(h_rnd));
            chk("hold_sn",    32'(bus.SN),    32'(h_sn));
            chk("hold_valid", 32'(bus.VALID), 32'(h_valid));
            chk("hold_wrap",  32'(bus.WRAP),  32'h0);
        end
        bus.EN = 1'b1;
        steps = 100; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            steps++;
            if (bus.WRAP) found = 1'b1;
        end
        chk("pause_wrap_found", 32'(found), 32'h1);
        chk("pause_wrap_steps", 32'(steps), 32'd255);
        chk("pause_wrap_rnd",   32'(bus.RND), 32'h01);

        // LOAD with EN in the same cycle
        repeat (20) tick();
        bus.SEED = 8'h5A; bus.LOAD = 1'b1; bus.EN = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        chk("load_rnd",   32'(bus.RND),   32'h5A);
        chk("load_valid", 32'(bus.VALID), 32'h0);
        chk("load_wrap",  32'(bus.WRAP),  32'h0);
        chk("load_sn",    32'(bus.SN),    32'h0);
        steps = 0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            steps++;
            if (bus.WRAP) found = 1'b1;
        end
        chk("load_wrap_steps", 32'(steps),   32'd255);
        chk("load_wrap_rnd",   32'(bus.RND), 32'h5A);

        // randomized traffic with frequent reseeds
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 199));
            RESET    = (r == 0);
            bus.LOAD = (r >= 1 && r <= 4);
            bus.SEED = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.EN   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) bus.PROB = 32'($urandom);
            tick();
        end
        // randomized traffic long enough to wrap several times
        RESET = 1'b0; bus.LOAD = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            bus.EN = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 31) == 0) bus.PROB = 32'($urandom);
            tick();
        end

`ifdef LFSR_SNG_CNT_EN
        RESET = 1'b1; bus.SEED = 8'h01; bus.EN = 1'b0; bus.PROB = 32'h00000037;
        tick();
        RESET = 1'b0; bus.EN = 1'b1;
        wraps = 0;
        for (int i = 0; i < 600 && wraps < 2; i++) begin
            tick();
            if (bus.WRAP) begin
                wraps++;
                chk("cnt_ch0_latched", 32'(bus.CNT[7:0]), 32'h37);
            end
        end
        chk("cnt_wraps", 32'(wraps), 32'd2);
`endif

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
